// File: rtl/qnigma_pkg.sv
// qnigma_pkg -- shared types and constants for the qnigma IPv6 router table.
//
// Provides the address types, the Router Advertisement metadata structures
// presented alongside a received RA, and the link defaults.
package qnigma_pkg;

  localparam int          PREFIX_LENGTH = 64;
  localparam logic [15:0] MTU_DEFAULT   = 16'd1500;

  typedef logic [47:0]  mac_t;
  typedef logic [127:0] ip_t;
  typedef logic [63:0]  pfx_t;   // on-link prefix, upper 64 bits of an address

  // IP header addresses of the received packet; rem is the RA source.
  typedef struct packed {
    ip_t rem;
    ip_t loc;
  } meta_ip_t;

  typedef struct packed {
    logic [15:0] lifetime;       // router lifetime in seconds
  } rtr_inf_t;

  typedef struct packed {
    logic [7:0]  lng;            // prefix length in bits
    pfx_t        pfx;
    logic [31:0] pfx_life;       // valid lifetime, all-ones = infinite
  } pfx_inf_t;

  typedef struct packed {
    logic [31:0] lifetime;       // all-ones = infinite
    ip_t         ip;
  } rdnss_t;

  typedef struct packed {
    rtr_inf_t    rtr;
    pfx_inf_t    opt_pfx_inf;
    rdnss_t      opt_rdnss;
    logic [31:0] opt_mtu;
  } meta_icmp_t;

  // Which parts of meta_icmp carry valid data for the current strobe.
  typedef struct packed {
    logic ra;
    logic opt_pfx_inf;
    logic opt_rdnss;
    logic opt_mtu;
  } meta_icmp_pres_t;

endpackage

// File: rtl/qnigma_rtr_tbl_if.sv
// qnigma_rtr_tbl_if -- Router Advertisement metadata bus.
//
// Signals:
//   rcv             one-cycle strobe, metadata below is valid
//   meta_mac        RA source MAC
//   meta_ip         RA source/destination IP
//   meta_icmp       RA body fields and options
//   meta_icmp_pres  per-field presence flags
// Modports: master drives the bus (parser side), slave consumes it (table).
interface qnigma_rtr_tbl_if;
  import qnigma_pkg::*;

  logic            rcv;
  mac_t            meta_mac;
  meta_ip_t        meta_ip;
  meta_icmp_t      meta_icmp;
  meta_icmp_pres_t meta_icmp_pres;

  modport master (output rcv, meta_mac, meta_ip, meta_icmp, meta_icmp_pres);
  modport slave  (input  rcv, meta_mac, meta_ip, meta_icmp, meta_icmp_pres);
endinterface

// File: rtl/qnigma_rtr_tbl.sv
// qnigma_rtr_tbl -- IPv6 default-router, prefix, RDNSS and MTU table.
//
// Learns state from received Router Advertisements and ages it on a
// 1-second tick.
//
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   tick_s       one-cycle 1-second tick
//   ra           RA metadata bus (slave)
//   rtr_ip/mac   selected default router (lowest-index valid entry)
//   rtr_det      at least one router known
//   rtr_cnt      number of valid router entries
//   pfx/pfx_vld  prefix table contents
//   dns_ip/avl   RDNSS server address and validity
//   mtu          link MTU
//   ovf          pulse: an RA entry was dropped because its table was full
module qnigma_rtr_tbl
  import qnigma_pkg::*;
#(
  parameter int RTR_N   = 4,
  parameter int PFX_N   = 2,
  parameter int PFX_LEN = PREFIX_LENGTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       tick_s,
  qnigma_rtr_tbl_if.slave            ra,
  output ip_t                        rtr_ip,
  output mac_t                       rtr_mac,
  output logic                       rtr_det,
  output logic [$clog2(RTR_N+1)-1:0] rtr_cnt,
  output pfx_t                       pfx [PFX_N],
  output logic [PFX_N-1:0]           pfx_vld,
  output ip_t                        dns_ip,
  output logic                       dns_avl,
  output logic [15:0]                mtu,
  output logic                       ovf
);

  localparam int          RIW      = (RTR_N > 1) ? $clog2(RTR_N) : 1;
  localparam int          PIW      = (PFX_N > 1) ? $clog2(PFX_N) : 1;
  localparam int          CW       = $clog2(RTR_N + 1);
  localparam logic [31:0] LIFE_INF = '1;

  // Router table storage
  logic        r_vld  [RTR_N];
  ip_t         r_ip   [RTR_N];
  mac_t        r_mac  [RTR_N];
  logic [15:0] r_life [RTR_N];

  // Prefix lifetimes (prefix values and valid flags live in the outputs)
  logic [31:0] p_life [PFX_N];

  logic [31:0] dns_life;
  logic        rtr_det_d;

  // Fields not consumed by this block
  logic unused_ok;
  assign unused_ok = ^{ra.meta_ip.loc, ra.meta_icmp.opt_pfx_inf.lng[7]};

  // ---------------------------------------------------------------------
  // Router table update decision: match, else lowest free, else replace
  // the shortest-lived entry if the new lifetime is strictly longer.
  // ---------------------------------------------------------------------
  logic           r_hit, r_free, r_wr, r_clr, r_drop;
  logic [RIW-1:0] r_hit_idx, r_free_idx, r_min_idx, r_idx;
  logic [15:0]    r_min_life, r_lt;

  // NOTE: every combinational output gets a default before any branch so
  // no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    r_lt       = ra.meta_icmp.rtr.lifetime;
    r_hit      = 1'b0;
    r_hit_idx  = '0;
    r_free     = 1'b0;
    r_free_idx = '0;
    r_min_idx  = '0;
    r_min_life = r_life[0];
    for (int i = 0; i < RTR_N; i++) begin
      if (r_vld[i] && (r_ip[i] == ra.meta_ip.rem)) begin
        r_hit     = 1'b1;
        r_hit_idx = RIW'(i);
      end
      if (!r_vld[i] && !r_free) begin
        r_free     = 1'b1;
        r_free_idx = RIW'(i);
      end
      // strict compare keeps ties on the lowest index
      if (r_life[i] < r_min_life) begin
        r_min_life = r_life[i];
        r_min_idx  = RIW'(i);
      end
    end

    r_wr   = 1'b0;
    r_clr  = 1'b0;
    r_drop = 1'b0;
    r_idx  = '0;
    if (ra.rcv && ra.meta_icmp_pres.ra) begin
      if (r_hit) begin
        r_idx = r_hit_idx;
        r_clr = (r_lt == '0);
        r_wr  = (r_lt != '0);
      end else if (r_lt != '0) begin
        if (r_free) begin
          r_wr  = 1'b1;
          r_idx = r_free_idx;
        end else if (r_lt > r_min_life) begin
          r_wr  = 1'b1;
          r_idx = r_min_idx;
        end else begin
          r_drop = 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Prefix table update decision, same policy keyed on the prefix value.
  // ---------------------------------------------------------------------
  logic           p_req, p_hit, p_free, p_wr, p_clr, p_drop;
  logic [PIW-1:0] p_hit_idx, p_free_idx, p_min_idx, p_idx;
  logic [31:0]    p_min_life, p_lt;

  always_comb begin
    p_lt  = ra.meta_icmp.opt_pfx_inf.pfx_life;
    p_req = ra.rcv && ra.meta_icmp_pres.opt_pfx_inf &&
            (ra.meta_icmp.opt_pfx_inf.lng[6:0] == 7'(PFX_LEN));
    p_hit      = 1'b0;
    p_hit_idx  = '0;
    p_free     = 1'b0;
    p_free_idx = '0;
    p_min_idx  = '0;
    p_min_life = p_life[0];
    for (int i = 0; i < PFX_N; i++) begin
      if (pfx_vld[i] && (pfx[i] == ra.meta_icmp.opt_pfx_inf.pfx)) begin
        p_hit     = 1'b1;
        p_hit_idx = PIW'(i);
      end
      if (!pfx_vld[i] && !p_free) begin
        p_free     = 1'b1;
        p_free_idx = PIW'(i);
      end
      if (p_life[i] < p_min_life) begin
        p_min_life = p_life[i];
        p_min_idx  = PIW'(i);
      end
    end

    p_wr   = 1'b0;
    p_clr  = 1'b0;
    p_drop = 1'b0;
    p_idx  = '0;
    if (p_req) begin
      if (p_hit) begin
        p_idx = p_hit_idx;
        p_clr = (p_lt == '0);
        p_wr  = (p_lt != '0);
      end else if (p_lt != '0) begin
        if (p_free) begin
          p_wr  = 1'b1;
          p_idx = p_free_idx;
        end else if (p_lt > p_min_life) begin
          p_wr  = 1'b1;
          p_idx = p_min_idx;
        end else begin
          p_drop = 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Router table state. The entry written by an RA takes the advertised
  // lifetime as-is even when a tick lands in the same cycle.
  // ---------------------------------------------------------------------
  // NOTE: state is assigned with <= so every flop samples the values from
  // before the edge, independent of statement order.
  // NOTE: the tables are small register arrays and are reset explicitly,
  // since stale valid bits after reset would advertise phantom routers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RTR_N; i++) begin
        r_vld[i]  <= 1'b0;
        r_ip[i]   <= '0;
        r_mac[i]  <= '0;
        r_life[i] <= '0;
      end
    end else begin
      for (int i = 0; i < RTR_N; i++) begin
        if (r_wr && (r_idx == RIW'(i))) begin
          r_vld[i]  <= 1'b1;
          r_ip[i]   <= ra.meta_ip.rem;
          r_mac[i]  <= ra.meta_mac;
          r_life[i] <= r_lt;
        end else if (r_clr && (r_idx == RIW'(i))) begin
          r_vld[i]  <= 1'b0;
          r_life[i] <= '0;
        end else if (tick_s && r_vld[i]) begin
          if (r_life[i] <= 16'd1) begin
            r_vld[i]  <= 1'b0;
            r_life[i] <= '0;
          end else begin
            r_life[i] <= r_life[i] - 16'd1;
          end
        end
      end
    end
  end

  // Prefix table state; all-ones lifetime never ages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pfx_vld <= '0;
      for (int i = 0; i < PFX_N; i++) begin
        pfx[i]    <= '0;
        p_life[i] <= '0;
      end
    end else begin
      for (int i = 0; i < PFX_N; i++) begin
        if (p_wr && (p_idx == PIW'(i))) begin
          pfx_vld[i] <= 1'b1;
          pfx[i]     <= ra.meta_icmp.opt_pfx_inf.pfx;
          p_life[i]  <= p_lt;
        end else if (p_clr && (p_idx == PIW'(i))) begin
          pfx_vld[i] <= 1'b0;
          p_life[i]  <= '0;
        end else if (tick_s && pfx_vld[i] && (p_life[i] != LIFE_INF)) begin
          if (p_life[i] <= 32'd1) begin
            pfx_vld[i] <= 1'b0;
            p_life[i]  <= '0;
          end else begin
            p_life[i] <= p_life[i] - 32'd1;
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Selected router and count, registered from the current table.
  // ---------------------------------------------------------------------
  logic           r_any;
  logic [RIW-1:0] r_sel;
  logic [CW-1:0]  r_num;

  always_comb begin
    r_any = 1'b0;
    r_sel = '0;
    r_num = '0;
    for (int i = RTR_N - 1; i >= 0; i--) begin
      if (r_vld[i]) begin
        r_any = 1'b1;
        r_sel = RIW'(i);
      end
      r_num = r_num + CW'(r_vld[i]);
    end
  end

  // With no router left, the last address is kept; rtr_det says it is stale.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rtr_det   <= 1'b0;
      rtr_det_d <= 1'b0;
      rtr_cnt   <= '0;
      rtr_ip    <= '0;
      rtr_mac   <= '0;
    end else begin
      rtr_det   <= r_any;
      rtr_det_d <= rtr_det;
      rtr_cnt   <= r_num;
      if (r_any) begin
        rtr_ip  <= r_ip[r_sel];
        rtr_mac <= r_mac[r_sel];
      end
    end
  end

  // ---------------------------------------------------------------------
  // RDNSS, MTU and overflow.
  // ---------------------------------------------------------------------
  logic mtu_ok;
  assign mtu_ok = ra.rcv && ra.meta_icmp_pres.opt_mtu &&
                  (ra.meta_icmp.opt_mtu[31:16] == '0) &&
                  (ra.meta_icmp.opt_mtu[15:0] >= 16'd1280) &&
                  (ra.meta_icmp.opt_mtu[15:0] <= MTU_DEFAULT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dns_avl  <= 1'b0;
      dns_ip   <= '0;
      dns_life <= '0;
      mtu      <= MTU_DEFAULT;
      ovf      <= 1'b0;
    end else begin
      ovf <= r_drop | p_drop;

      if (ra.rcv && ra.meta_icmp_pres.opt_rdnss) begin
        if (ra.meta_icmp.opt_rdnss.lifetime != '0) begin
          dns_avl  <= 1'b1;
          dns_ip   <= ra.meta_icmp.opt_rdnss.ip;
          dns_life <= ra.meta_icmp.opt_rdnss.lifetime;
        end else begin
          dns_avl  <= 1'b0;
          dns_life <= '0;
        end
      end else if (tick_s && dns_avl && (dns_life != LIFE_INF)) begin
        if (dns_life <= 32'd1) begin
          dns_avl  <= 1'b0;
          dns_life <= '0;
        end else begin
          dns_life <= dns_life - 32'd1;
        end
      end

      // Losing the last router falls back to the default link MTU the
      // cycle after rtr_cnt reaches zero.
      if (rtr_det_d && !rtr_det) begin
        mtu <= MTU_DEFAULT;
      end else if (mtu_ok) begin
        mtu <= ra.meta_icmp.opt_mtu[15:0];
      end
    end
  end

endmodule

// File: tb/tb_qnigma_rtr_tbl.sv
// tb_qnigma_rtr_tbl -- self-checking bench for qnigma_rtr_tbl (RTR_N=4,
// PFX_N=2). Expected values are queued when stimulus is applied and popped
// when the corresponding output is sampled on the falling clock edge.
module tb_qnigma_rtr_tbl;
  import qnigma_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic tick_s;
  always #5 clk = ~clk;

  qnigma_rtr_tbl_if bus ();

  ip_t         rtr_ip;
  mac_t        rtr_mac;
  logic        rtr_det;
  logic [2:0]  rtr_cnt;
  pfx_t        pfx [2];
  logic [1:0]  pfx_vld;
  ip_t         dns_ip;
  logic        dns_avl;
  logic [15:0] mtu;
  logic        ovf;

  qnigma_rtr_tbl #(.RTR_N(4), .PFX_N(2), .PFX_LEN(64)) dut (
    .clk(clk), .rst(rst), .tick_s(tick_s), .ra(bus),
    .rtr_ip(rtr_ip), .rtr_mac(rtr_mac), .rtr_det(rtr_det), .rtr_cnt(rtr_cnt),
    .pfx(pfx), .pfx_vld(pfx_vld), .dns_ip(dns_ip), .dns_avl(dns_avl),
    .mtu(mtu), .ovf(ovf)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [127:0] exp_q [$];
  logic [127:0] e;

  localparam pfx_t PA = 64'h2001_0db8_0000_0001;
  localparam pfx_t PB = 64'h2001_0db8_0000_0002;
  localparam pfx_t PC = 64'h2001_0db8_0000_0003;

  function automatic ip_t ip_of(input int n);
    return {112'h2001_0db8_0000_0000_0000_0000_00ff, 16'(n)};
  endfunction

  function automatic mac_t mac_of(input int n);
    return {32'h0200_5e00, 16'(n)};
  endfunction

  // ---------------- stimulus (called on a falling edge) ----------------
  task automatic step(input logic r, input meta_icmp_pres_t p,
                      input meta_icmp_t m, input int src, input logic t);
    bus.rcv            = r;
    bus.meta_icmp_pres = p;
    bus.meta_icmp      = m;
    bus.meta_ip.rem    = ip_of(src);
    bus.meta_ip.loc    = '0;
    bus.meta_mac       = mac_of(src);
    tick_s             = t;
    @(negedge clk);
    bus.rcv            = 1'b0;
    bus.meta_icmp_pres = '0;
    tick_s             = 1'b0;
  endtask

  task automatic send_rtr(input int src, input logic [15:0] lt, input logic t);
    meta_icmp_t m; meta_icmp_pres_t p;
    m = '0; p = '0; p.ra = 1'b1; m.rtr.lifetime = lt;
    step(1'b1, p, m, src, t);
  endtask

  task automatic send_rtr_notype(input int src, input logic [15:0] lt);
    meta_icmp_t m; meta_icmp_pres_t p;
    m = '0; p = '0; m.rtr.lifetime = lt;
    step(1'b1, p, m, src, 1'b0);
  endtask

  task automatic send_pfx(input pfx_t v, input logic [7:0] lng, input logic [31:0] life);
    meta_icmp_t m; meta_icmp_pres_t p;
    m = '0; p = '0; p.opt_pfx_inf = 1'b1;
    m.opt_pfx_inf.pfx = v; m.opt_pfx_inf.lng = lng; m.opt_pfx_inf.pfx_life = life;
    step(1'b1, p, m, 0, 1'b0);
  endtask

  task automatic send_dns(input int n, input logic [31:0] lt, input logic has);
    meta_icmp_t m; meta_icmp_pres_t p;
    m = '0; p = '0; p.opt_rdnss = has;
    m.opt_rdnss.ip = ip_of(n); m.opt_rdnss.lifetime = lt;
    step(1'b1, p, m, 0, 1'b0);
  endtask

  task automatic send_mtu(input logic [31:0] v);
    meta_icmp_t m; meta_icmp_pres_t p;
    m = '0; p = '0; p.opt_mtu = 1'b1; m.opt_mtu = v;
    step(1'b1, p, m, 0, 1'b0);
  endtask

  task automatic ticks(input int n);
    repeat (n) step(1'b0, '0, '0, 0, 1'b1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; tick_s = 1'b0;
    bus.rcv = 1'b0; bus.meta_icmp_pres = '0; bus.meta_icmp = '0;
    bus.meta_ip = '0; bus.meta_mac = '0;
    idle(2);
    rst = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0);
    exp_q.push_back(128'd1500); exp_q.push_back(0); exp_q.push_back(0);
    e = exp_q.pop_front(); n_checks++;
    if (128'(rtr_det) !== e) begin n_errors++; $display("FAIL reset_det got %0h want %0h", rtr_det, e); end
    e = exp_q.pop_front(); n_checks++;
    if (128'(rtr_cnt) !== e) begin n_errors++; $display("FAIL reset_cnt got %0h want %0h", rtr_cnt, e); end
    e = exp_q.pop_front(); n_checks++;
    if (rtr_ip !== e) begin n_errors++; $display("FAIL reset_ip got %0h want %0h", rtr_ip, e); end
    e = exp_q.pop_front(); n_checks++;
    if (128'(mtu) !== e) begin n_errors++; $display("FAIL reset_mtu got %0d want %0d", mtu, e); end
    e = exp_q.pop_front(); n_checks++;
    if (128'(pfx_vld) !== e) begin n_errors++; $display("FAIL reset_pfx_vld got %0h want %0h", pfx_vld, e); end
    e = exp_q.pop_front(); n_checks++;
    if (128'({dns_avl, ovf}) !== e) begin n_errors++; $display("FAIL reset_dns_ovf got %0h want %0h", {dns_avl, ovf}, e); end
  endtask

  task automatic test_router_basic();
    send_rtr(1, 16'd3, 1'b0);
    send_rtr(2, 16'd1800, 1'b0);
    exp_q.push_back(2); exp_q.push_back(ip_of(1)); exp_q.push_back(128'(mac_of(1)));
    idle(1);
    e = exp_q.pop_front(); n_checks++;
    if (128'(rtr_cnt) !== e) begin n_errors++; $display("FAIL basic_cnt got %0d want %0d", rtr_cnt, e); end
    e = exp_q.pop_front(); n_checks++;
    if (rtr_ip !== e) begin n_errors++; $display("FAIL basic_sel_ip got %0h want %0h", rtr_ip, e); end
    e = exp_q.pop_front(); n_checks++;
    if (128'(rtr_mac) !== e) begin n_errors++; $display("FAIL basic_sel_mac got %0h want %0h", rtr_mac, e); end
    ticks(3);
    exp_q.push_back(1); exp_q.push_back(ip_of(2));
    idle(1);
    e = exp_q.pop_front(); n_checks++;
    if (128'(rtr_cnt) !== e) begin n_errors++; $display("FAIL expire_cnt got %0d want %0d", rtr_cnt, e); end
    e = exp_q.pop_front(); n_checks++;
    if (rtr_ip !== e) begin n_errors++; $display("FAIL expire_sel_ip got %0h want %0h", rtr_ip, e); end
  endtask

  task automatic test_mtu();
    logic [31:0] vals [5];
    logic [15:0] want [5];
    vals = '{32'd1000, 32'd70000, 32'h0001_0578, 32'd1400, 32'd1501};
    want = '{16'd1500, 16'd1500, 16'd1500, 16'd1400, 16'd1400};
    for (int i = 0; i < 5; i++) begin
      send_mtu(vals[i]);
      exp_q.push_back(128'(want[i]));
      e = exp_q.pop_front(); n_checks++;
      if (128'(mtu) !== e) begin n_errors++; $display("FAIL mtu_opt_%0d got %0d want %0d", i, mtu, e); end
    end
  endtask

  task automatic test_withdraw();
    send_rtr(2, 16'd0, 1'b0);
    exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(ip_of(2)); exp_q.push_back(128'd1500);
    idle(2);
    e = exp_q.pop_front(); n_checks++;
    if (128'(rtr_det) !== e) begin n_errors++; $display("FAIL withdraw_det got %0d want %0d", rtr_det, e); end
    e = exp_q.pop_front(); n_checks++;
    if (128'(rtr_cnt) !== e) begin n_errors++; $display("FAIL withdraw_cnt got %0d want %0d", rtr_cnt, e); end
    e = exp_q.pop_front(); n_checks++;
    if (rtr_ip !== e) begin n_errors++; $display("FAIL withdraw_hold_ip got %0h want %0h", rtr_ip, e); end
    e = exp_q.pop_front(); n_checks++;
    if (128'(mtu) !== e) begin n_errors++; $display("FAIL withdraw_mtu got %0d want %0d", mtu, e); end
  endtask

  task automatic test_replace();
    send_rtr(10, 16'd10, 1'b0);
    send_rtr(11, 16'd5, 1'b0);
    send_rtr(12, 16'd5, 1'b0);
    send_rtr(13, 16'd20, 1'b0);
    send_rtr(14, 16'd6, 1'b0);          // replaces index 1 (smallest, lowest tie)
    exp_q.push_back(0);
    e = exp_q.pop_front(); n_checks++;
    if (128'(ovf) !== e) begin n_errors++; $display("FAIL replace_no_ovf got %0d want %0d", ovf, e); end
    send_rtr(15, 16'd4, 1'b0);          // not longer than min life 5: dropped
    exp_q.push_back(1); exp_q.push_back(0); exp_q.push_back(4);
    e = exp_q.pop_front(); n_checks++;
    if (128'(ovf) !== e) begin n_errors++; $display("FAIL drop_ovf got %0d want %0d", ovf, e); end
    idle(1);
    e = exp_q.pop_front(); n_checks++;
    if (128'(ovf) !== e) begin n_errors++; $display("FAIL drop_ovf_once got %0d want %0d", ovf, e); end
    e = exp_q.pop_front(); n_checks++;
    if (128'(rtr_cnt) !== e) begin n_errors++; $display("FAIL full_cnt got %0d want %0d", rtr_cnt, e); end
    send_rtr(10, 16'd0, 1'b0);          // withdraw index 0 to expose index 1
    send_rtr(11, 16'd0, 1'b0);          // already replaced: ignored
    send_rtr_notype(20, 16'd9);         // no RA type: router table ignores it
    exp_q.push_back(ip_of(14)); exp_q.push_back(3);
    idle(1);
    e = exp_q.pop_front(); n_checks++;
    if (rtr_ip !== e) begin n_errors++; $display("FAIL replace_idx1_ip got %0h want %0h", rtr_ip, e); end
    e = exp_q.pop_front(); n_checks++;
    if (128'(rtr_cnt) !== e) begin n_errors++; $display("FAIL ignore_cnt got %0d want %0d", rtr_cnt, e); end
  endtask

  task automatic test_prefix();
    send_pfx(PA, 8'd48, 32'd100);
    exp_q.push_back(2'b00);
    e = exp_q.pop_front(); n_checks++;
    if (128'(pfx_vld) !== e) begin n_errors++; $display("FAIL pfx_len48 got %0b want %0b", pfx_vld, e); end
    send_pfx(PA, 8'd64, 32'hFFFF_FFFF);
    send_pfx(PB, 8'd64, 32'd2);
    exp_q.push_back(2'b11); exp_q.push_back(128'(PA));
    e = exp_q.pop_front(); n_checks++;
    if (128'(pfx_vld) !== e) begin n_errors++; $display("FAIL pfx_load got %0b want %0b", pfx_vld, e); end
    e = exp_q.pop_front(); n_checks++;
    if (128'(pfx[0]) !== e) begin n_errors++; $display("FAIL pfx0_val got %0h want %0h", pfx[0], e); end
    ticks(2);
    exp_q.push_back(2'b01);
    e = exp_q.pop_front(); n_checks++;
    if (128'(pfx_vld) !== e) begin n_errors++; $display("FAIL pfx_expire got %0b want %0b", pfx_vld, e); end
    send_pfx(PB, 8'd64, 32'd2);
    send_pfx(PC, 8'd64, 32'd1);         // full, 1 not > 2: dropped
    exp_q.push_back(1);
    e = exp_q.pop_front(); n_checks++;
    if (128'(ovf) !== e) begin n_errors++; $display("FAIL pfx_ovf got %0d want %0d", ovf, e); end
    ticks(100);
    exp_q.push_back(2'b01);
    e = exp_q.pop_front(); n_checks++;
    if (128'(pfx_vld) !== e) begin n_errors++; $display("FAIL pfx_infinite got %0b want %0b", pfx_vld, e); end
    send_pfx(PA, 8'd64, 32'd0);
    exp_q.push_back(2'b00);
    e = exp_q.pop_front(); n_checks++;
    if (128'(pfx_vld) !== e) begin n_errors++; $display("FAIL pfx_withdraw got %0b want %0b", pfx_vld, e); end
  endtask

  task automatic test_dns();
    send_dns(30, 32'd2, 1'b1);
    send_dns(31, 32'd5, 1'b0);          // no RDNSS option: unchanged
    exp_q.push_back(1); exp_q.push_back(ip_of(30));
    e = exp_q.pop_front(); n_checks++;
    if (128'(dns_avl) !== e) begin n_errors++; $display("FAIL dns_load got %0d want %0d", dns_avl, e); end
    e = exp_q.pop_front(); n_checks++;
    if (dns_ip !== e) begin n_errors++; $display("FAIL dns_ip got %0h want %0h", dns_ip, e); end
    ticks(1);
    exp_q.push_back(1);
    e = exp_q.pop_front(); n_checks++;
    if (128'(dns_avl) !== e) begin n_errors++; $display("FAIL dns_tick1 got %0d want %0d", dns_avl, e); end
    ticks(1);
    exp_q.push_back(0);
    e = exp_q.pop_front(); n_checks++;
    if (128'(dns_avl) !== e) begin n_errors++; $display("FAIL dns_expire got %0d want %0d", dns_avl, e); end
    send_dns(32, 32'd10, 1'b1);
    send_dns(32, 32'd0, 1'b1);
    exp_q.push_back(0);
    e = exp_q.pop_front(); n_checks++;
    if (128'(dns_avl) !== e) begin n_errors++; $display("FAIL dns_clear got %0d want %0d", dns_avl, e); end
  endtask

  task automatic test_rcv_tick_collision();
    do_reset();
    send_rtr(1, 16'd3, 1'b0);
    send_rtr(2, 16'd3, 1'b0);
    send_rtr(1, 16'd2, 1'b1);           // A = 2 (no decrement), B 3 -> 2
    ticks(1);
    exp_q.push_back(2);
    idle(1);
    e = exp_q.pop_front(); n_checks++;
    if (128'(rtr_cnt) !== e) begin n_errors++; $display("FAIL collide_tick1_cnt got %0d want %0d", rtr_cnt, e); end
    ticks(1);
    exp_q.push_back(0);
    idle(1);
    e = exp_q.pop_front(); n_checks++;
    if (128'(rtr_cnt) !== e) begin n_errors++; $display("FAIL collide_tick2_cnt got %0d want %0d", rtr_cnt, e); end
  endtask

  task automatic test_reset_mid();
    send_mtu(32'd1400);
    send_rtr(5, 16'd100, 1'b0);
    send_pfx(PA, 8'd64, 32'd50);
    send_dns(40, 32'd50, 1'b1);
    idle(1);
    send_rtr(5, 16'd7, 1'b1);
    rst = 1'b1;
    #1;
    exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(128'd1500);
    exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0);
    e = exp_q.pop_front(); n_checks++;
    if (128'({rtr_det, rtr_cnt}) !== e) begin n_errors++; $display("FAIL rst_rtr got %0h want %0h", {rtr_det, rtr_cnt}, e); end
    e = exp_q.pop_front(); n_checks++;
    if (rtr_ip !== e) begin n_errors++; $display("FAIL rst_ip got %0h want %0h", rtr_ip, e); end
    e = exp_q.pop_front(); n_checks++;
    if (128'(mtu) !== e) begin n_errors++; $display("FAIL rst_mtu got %0d want %0d", mtu, e); end
    e = exp_q.pop_front(); n_checks++;
    if (128'({pfx_vld, pfx[0]}) !== e) begin n_errors++; $display("FAIL rst_pfx got %0h want %0h", {pfx_vld, pfx[0]}, e); end
    e = exp_q.pop_front(); n_checks++;
    if (128'({dns_avl, ovf}) !== e) begin n_errors++; $display("FAIL rst_dns_ovf got %0h want %0h", {dns_avl, ovf}, e); end
    e = exp_q.pop_front(); n_checks++;
    if (dns_ip !== e) begin n_errors++; $display("FAIL rst_dns_ip got %0h want %0h", dns_ip, e); end
    @(negedge clk);
    rst = 1'b0;
    send_rtr(6, 16'd9, 1'b0);
    exp_q.push_back(1); exp_q.push_back(ip_of(6));
    idle(1);
    e = exp_q.pop_front(); n_checks++;
    if (128'(rtr_cnt) !== e) begin n_errors++; $display("FAIL post_rst_cnt got %0d want %0d", rtr_cnt, e); end
    e = exp_q.pop_front(); n_checks++;
    if (rtr_ip !== e) begin n_errors++; $display("FAIL post_rst_ip got %0h want %0h", rtr_ip, e); end
  endtask

  initial begin
    rst = 1'b1;
    tick_s = 1'b0;
    @(negedge clk);
    test_reset();
    test_router_basic();
    test_mtu();
    test_withdraw();
    test_replace();
    test_prefix();
    test_dns();
    test_rcv_tick_collision();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/qnigma_rtr_tbl.md
QNIGMA_RTR_TBL -- requirements
Module: qnigma_rtr_tbl

Interface
REQ-001 Parameter RTR_N, default 4: default-router table entries (1..16).
REQ-002 Parameter PFX_N, default 2: prefix table entries (1..8).
REQ-003 Parameter PFX_LEN, default PREFIX_LENGTH: only accepted prefix length.
REQ-004 clk  in  1  single clock; all state on posedge clk.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 tick_s  in  1  one-cycle 1-second tick.
REQ-007 rcv  in  1  one-cycle strobe: valid Router Advertisement metadata present.
REQ-008 meta_mac, meta_ip, meta_icmp, meta_icmp_pres  in  package types  RA source MAC/IP, RA fields, option-present flags.
REQ-009 rtr_ip, rtr_mac  out  ip_t, mac_t  selected default router.
REQ-010 rtr_det  out  1  at least one router entry valid.
REQ-011 rtr_cnt  out  $clog2(RTR_N+1)  number of valid router entries.
REQ-012 pfx  out  PFX_N x pfx_t; pfx_vld  out  PFX_N  per-entry prefix and valid flag.
REQ-013 dns_ip  out  ip_t; dns_avl  out  1  RDNSS address and validity.
REQ-014 mtu  out  16  link MTU.
REQ-015 ovf  out  1  one-cycle pulse: RA entry dropped because its table was full.

Function
REQ-016 Router entry fields: vld, ip, mac, life[15:0]; key = meta_ip.rem.
REQ-017 On rcv, match = any vld entry with ip == meta_ip.rem; at most one match.
REQ-018 Match and rtr.lifetime==0: clear the entry's vld (router withdrawn).
REQ-019 Match and lifetime!=0: overwrite mac and life.
REQ-020 No match and lifetime==0: ignore.
REQ-021 No match, lifetime!=0: allocate the lowest-index free entry.
REQ-022 If no entry is free, replace the entry with the smallest life, ties to the lowest index, only if the new lifetime is strictly greater; otherwise drop and pulse ovf.
REQ-023 Selected router = lowest-index valid entry. rtr_ip, rtr_mac, rtr_det and rtr_cnt are registered and reflect the table one cycle after any table change.
REQ-024 When no entry is valid, rtr_ip and rtr_mac hold their last value and rtr_det=0.
REQ-025 On tick_s, every valid router entry decrements life. An entry with life==1 at the tick becomes invalid in the same cycle.
REQ-026 rcv and tick_s in the same cycle: the entry written by rcv takes the RA value without decrement; all other entries decrement.
REQ-027 Prefix entry fields: vld, pfx, life[31:0]; key = opt_pfx_inf.pfx.
REQ-028 A prefix is processed only when opt_pfx_inf is present and lng[6:0]==PFX_LEN. Match, allocate, replace, ovf, withdraw and tick rules follow REQ-017..REQ-026, using pfx_life.
REQ-029 A prefix life of 32'hFFFFFFFF means infinite and is never decremented.
REQ-030 ovf is asserted if either table drops an entry in that cycle.
REQ-031 DNS is updated only when opt_rdnss is present: lifetime!=0 loads dns_ip and the 32-bit life and sets dns_avl; lifetime==0 clears dns_avl.
REQ-032 An RA without RDNSS leaves DNS state unchanged.
REQ-033 DNS life decrements on tick_s under the same infinite (all-ones) and expiry rules as prefixes.
REQ-034 An MTU option is accepted only if bits [31:16]==0 and 1280 <= [15:0] <= MTU_DEFAULT; otherwise mtu is unchanged.
REQ-035 mtu reverts to MTU_DEFAULT on the cycle after rtr_cnt becomes 0.
REQ-036 All lifetime arithmetic saturates at 0; no wrap-around.
REQ-037 rcv is ignored for the router table unless the RA type is present in meta_icmp_pres; options are processed regardless.

Reset
REQ-038 Reset clears all vld bits, all lives, rtr_det, rtr_cnt, pfx_vld, dns_avl and ovf, and sets mtu=MTU_DEFAULT.
REQ-039 Reset clears rtr_ip, rtr_mac, pfx and dns_ip to zero.
REQ-040 Reset asserted mid-update overrides rcv and tick_s. Outputs take reset values asynchronously; the first rcv after deassertion is processed normally.

Verification
REQ-041 Two RAs from IP A (lifetime 3) then IP B (1800) -> rtr_cnt=2, selected router=A. After 3 tick_s -> A expires, selected router=B, rtr_cnt=1.
REQ-042 RTR_N=4 full (lives 10,5,5,20); RA from new IP with lifetime 6 -> replaces index 1. Same RA with lifetime 4 -> dropped, ovf pulses once.
REQ-043 RA with a matching IP and lifetime 0 -> entry cleared next cycle. With the only router gone, rtr_det=0 and mtu=MTU_DEFAULT.
REQ-044 Prefix of length 48 -> ignored. Prefix of length 64 with life FFFFFFFF -> pfx_vld stays 1 after 100 tick_s.
REQ-045 MTU option 1000, then 70000, then 1400 -> mtu unchanged, unchanged, then 1400 (with MTU_DEFAULT=1500).
REQ-046 rcv for entry X and tick_s in the same cycle -> X life equals the RA value, other entries decrement by 1; rst asserted next cycle -> all outputs at reset values.
